cart_rom_fetch: RTL and testbench

- Responder on the far end of the cartridge ROM read path.
- Accepts the one-cycle `cart_read` strobe and 25-bit byte address issued by the console core.
- Fetches 16-bit words from external SDRAM/DDR through a req/ack handshake and returns the addressed byte on `cart_out`.
- Holds a one-word hit buffer, so repeated reads of the same word do not reach memory; sits between the console core and the platform memory controller.

---
 rtl/cart_rom_fetch.sv | 236 +++++++++++++++++++++++
 tb/tb_cart_rom_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_rom_fetch.sv
// rtl/cart_rom_fetch.sv - cartridge ROM byte fetch with a one-word hit buffer
// Purpose: serves one-cycle cart_read strobes from the console core. A read whose word is
//   in the buffer returns one cycle later. Otherwise the word is fetched over mem_req/mem_ack
//   and the byte returns on the edge after the mem_ack edge.
// Ports: clk_sys, reset (sync, active-high), loading (ROM download, flushes buffer),
//   cart_read/cart_addr (byte read request), cart_out/cart_valid (byte return),
//   mem_req/mem_addr/mem_ack/mem_rdata (word fetch handshake), overrun (sticky lost-read flag).
// Optional: define CART_PREFETCH_EN to add a prefetched next-word entry.
module cart_rom_fetch #(
    parameter int ADDR_W     = 25,
    parameter bit PENDING_EN = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              loading,
    input  logic              cart_read,
    input  logic [ADDR_W-1:0] cart_addr,
    output logic [7:0]        cart_out,
    output logic              cart_valid,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              overrun
);
    localparam int WA_W = ADDR_W - 1;

    // S_RESP is the cycle between the ack edge and the return edge; reads seen there queue
    // like reads seen in S_REQ so a return and a hit never collide on the same edge.
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN, S_PF} state_t;

    state_t            state_q, state_d;
    logic              buf_valid_q, buf_valid_d;
    logic [WA_W-1:0]   buf_tag_q, buf_tag_d;
    logic [15:0]       buf_data_q, buf_data_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              fetch_lsb_q, fetch_lsb_d;
    logic [7:0]        ret_byte_q, ret_byte_d;
    logic              mem_req_q, mem_req_d;
    logic [WA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]        cart_out_q, cart_out_d;
    logic              cart_valid_q, cart_valid_d;
    logic              overrun_q, overrun_d;
`ifdef CART_PREFETCH_EN
    logic              pf_valid_q, pf_valid_d;
    logic [WA_W-1:0]   pf_tag_q, pf_tag_d;
    logic [15:0]       pf_data_q, pf_data_d;
    logic              hit_pf;
    logic [7:0]        pf_byte;
`endif

    logic              rd_en;
    logic [ADDR_W-1:0] look_addr;
    logic [WA_W-1:0]   look_word;
    logic              hit_main;
    logic [7:0]        main_byte;

    assign rd_en = cart_read && !loading;

    // Lookup uses the live read in IDLE and the queued read in DRAIN.
    always_comb begin
        look_addr = (state_q == S_DRAIN) ? pend_addr_q : cart_addr;
        look_word = look_addr[ADDR_W-1:1];
        hit_main  = buf_valid_q && (buf_tag_q == look_word);
        main_byte = look_addr[0] ? buf_data_q[15:8] : buf_data_q[7:0];
`ifdef CART_PREFETCH_EN
        hit_pf    = pf_valid_q && (pf_tag_q == look_word);
        pf_byte   = look_addr[0] ? pf_data_q[15:8] : pf_data_q[7:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        fetch_lsb_d  = fetch_lsb_q;
        ret_byte_d   = ret_byte_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        cart_out_d   = cart_out_q;
        cart_valid_d = 1'b0;
        overrun_d    = overrun_q;
`ifdef CART_PREFETCH_EN
        pf_valid_d   = pf_valid_q;
        pf_tag_d     = pf_tag_q;
        pf_data_d    = pf_data_q;
`endif

        // The slot is consumed in DRAIN, so a read arriving there refills it without loss.
        if (state_q == S_DRAIN) pend_valid_d = 1'b0;
        if (rd_en && state_q != S_IDLE) begin
            if (PENDING_EN) begin
                if (pend_valid_d) overrun_d = 1'b1;
                pend_valid_d = 1'b1;
                pend_addr_d  = cart_addr;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (loading) pend_valid_d = 1'b0;

        case (state_q)
            S_IDLE, S_DRAIN: begin
                if (state_q == S_DRAIN) state_d = S_IDLE;
                if ((state_q == S_DRAIN) ? !loading : rd_en) begin
                    if (hit_main) begin
                        cart_out_d   = main_byte;
                        cart_valid_d = 1'b1;
                        state_d      = pend_valid_d ? S_DRAIN : S_IDLE;
                    end
`ifdef CART_PREFETCH_EN
                    else if (hit_pf) begin
                        // Prefetched word becomes main; fetch the word after it.
                        cart_out_d   = pf_byte;
                        cart_valid_d = 1'b1;
                        buf_valid_d  = 1'b1;
                        buf_tag_d    = pf_tag_q;
                        buf_data_d   = pf_data_q;
                        pf_valid_d   = buf_valid_q;
                        pf_tag_d     = buf_tag_q;
                        pf_data_d    = buf_data_q;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = pf_tag_q + WA_W'(1);
                        state_d      = S_PF;
                    end
`endif
                    else begin
                        mem_req_d   = 1'b1;
                        mem_addr_d  = look_word;
                        fetch_lsb_d = look_addr[0];
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    ret_byte_d = fetch_lsb_q ? mem_rdata[15:8] : mem_rdata[7:0];
                    // Data fetched during a download may be stale; return it but do not keep it.
                    if (!loading) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = mem_addr_q;
                        buf_data_d  = mem_rdata;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cart_out_d   = ret_byte_q;
                cart_valid_d = 1'b1;
                state_d      = pend_valid_d ? S_DRAIN : S_IDLE;
`ifdef CART_PREFETCH_EN
                if (!pend_valid_d && !loading && buf_valid_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = buf_tag_q + WA_W'(1);
                    state_d    = S_PF;
                end
`endif
            end
`ifdef CART_PREFETCH_EN
            S_PF: begin
                // A prefetch cannot be aborted; demand reads wait in the pending slot.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!loading) begin
                        pf_valid_d = 1'b1;
                        pf_tag_d   = mem_addr_q;
                        pf_data_d  = mem_rdata;
                    end
                    state_d = pend_valid_d ? S_DRAIN : S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (loading) begin
            buf_valid_d = 1'b0;
`ifdef CART_PREFETCH_EN
            pf_valid_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_valid_q  <= 1'b0;
            buf_tag_q    <= '0;
            buf_data_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            fetch_lsb_q  <= 1'b0;
            ret_byte_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cart_out_q   <= '0;
            cart_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef CART_PREFETCH_EN
            pf_valid_q   <= 1'b0;
            pf_tag_q     <= '0;
            pf_data_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buf_valid_q  <= buf_valid_d;
            buf_tag_q    <= buf_tag_d;
            buf_data_q   <= buf_data_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            fetch_lsb_q  <= fetch_lsb_d;
            ret_byte_q   <= ret_byte_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            cart_out_q   <= cart_out_d;
            cart_valid_q <= cart_valid_d;
            overrun_q    <= overrun_d;
`ifdef CART_PREFETCH_EN
            pf_valid_q   <= pf_valid_d;
            pf_tag_q     <= pf_tag_d;
            pf_data_q    <= pf_data_d;
`endif
        end
    end

    assign cart_out   = cart_out_q;
    assign cart_valid = cart_valid_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb/tb_cart_rom_fetch.sv - scoreboard bench for cart_rom_fetch (default build)
module tb_cart_rom_fetch;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        loading = 1'b0;
    logic        cart_read = 1'b0;
    logic [24:0] cart_addr = '0;
    logic [7:0]  cart_out;
    logic        cart_valid;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        overrun;

    cart_rom_fetch #(.ADDR_W(25), .PENDING_EN(1'b1)) dut (
        .clk_sys(clk_sys), .reset(reset), .loading(loading),
        .cart_read(cart_read), .cart_addr(cart_addr),
        .cart_out(cart_out), .cart_valid(cart_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    int          last_valid_cyc = 0;
    int          valid_cnt = 0;
    int          push_cnt = 0;
    bit          auto_ack = 1'b0;
    int          ack_lat = 3;
    logic [7:0]  exp_q[$];
    logic [23:0] req_log[$];

    function automatic logic [15:0] mem_word(input logic [23:0] wa);
        if (wa == 24'h00091A) return 16'hBEEF;
        return {~wa[7:0], wa[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        push_cnt++;
    endtask

    // Caller is at a negedge; the strobe is high for exactly one cycle.
    task automatic rd(input logic [24:0] a);
        cart_read = 1'b1;
        cart_addr = a;
        @(negedge clk_sys);
        cart_read = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk_sys);
            n++;
        end
        @(negedge clk_sys);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout actual_left=%0d required=0", name, exp_q.size());
        end
    endtask

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    // Memory model: acks ack_lat cycles after mem_req is seen.
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk_sys);
            if (auto_ack) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    wcnt = 0;
                end else if (mem_req) begin
                    wcnt++;
                    if (wcnt >= ack_lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_word(mem_addr);
                        ack_cyc   = cyc;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: logs requests and checks every returned byte against the scoreboard.
    initial begin
        logic prev_req = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !prev_req) req_log.push_back(mem_addr);
            prev_req = mem_req;
            if (cart_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=0x%0h required=no_return", cart_out);
                end else begin
                    chk("scoreboard_byte", {24'h0, cart_out}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vc;
        int hits;

        // Reset state
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cart_out", cart_out, 0);
        chk("rst_cart_valid", cart_valid, 0);
        chk("rst_overrun", overrun, 0);

        // Miss at 0x1234: word 0x91A, byte 0 of 0xBEEF
        auto_ack = 1'b1;
        ack_lat = 3;
        n = req_log.size();
        expect_byte(8'hEF);
        rd(25'h0001234);
        wait_drain("miss_1234", 40);
        chk("miss_req_count", req_log.size(), n + 1);
        chk("miss_req_addr", req_log[n], 24'h00091A);
        chk("miss_latency", last_valid_cyc - ack_cyc, 2);
        chk("miss_no_overrun", overrun, 0);

        // Hits in the same word: no memory traffic, one-cycle latency
        n = req_log.size();
        expect_byte(8'hBE);
        rd(25'h0001235);
        chk("hit_1235_lat", cart_valid, 1);
        expect_byte(8'hEF);
        rd(25'h0001234);
        chk("hit_1234_lat", cart_valid, 1);
        @(negedge clk_sys);
        chk("hit_no_req", req_log.size(), n);

        // Two reads during a fetch: latest wins, overrun set
        ack_lat = 6;
        n = req_log.size();
        expect_byte(8'h20);
        rd(25'h0000040);
        rd(25'h0000010);
        expect_byte(8'h10);
        rd(25'h0000020);
        chk("overrun_set", overrun, 1);
        wait_drain("pending_drain", 80);
        chk("pend_req_count", req_log.size(), n + 2);
        chk("pend_req_first", req_log[n], 24'h000020);
        chk("pend_req_second", req_log[n+1], 24'h000010);
        hits = 0;
        foreach (req_log[i]) if (req_log[i] == 24'h000008) hits++;
        chk("dropped_never_fetched", hits, 0);

        // Loading flushes the buffer and swallows a read
        n = req_log.size();
        expect_byte(8'h10);
        rd(25'h0000020);
        chk("hit_before_load", cart_valid, 1);
        loading = 1'b1;
        cart_read = 1'b1;
        cart_addr = 25'h0000020;
        @(negedge clk_sys);
        loading = 1'b0;
        cart_read = 1'b0;
        chk("load_read_ignored", cart_valid, 0);
        chk("load_hit_no_req", req_log.size(), n);
        expect_byte(8'h10);
        rd(25'h0000020);
        wait_drain("refetch_after_load", 40);
        chk("refetch_req_count", req_log.size(), n + 1);
        chk("refetch_req_addr", req_log[n], 24'h000010);

        // Reset while a fetch is outstanding, late ack ignored
        auto_ack = 1'b0;
        rd(25'h0000300);
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_addr", mem_addr, 24'h000180);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("rst_drops_req", mem_req, 0);
        vc = valid_cnt;
        @(negedge clk_sys);
        mem_rdata = 16'h5A5A;
        mem_ack = 1'b1;
        @(negedge clk_sys);
        mem_ack = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("late_ack_no_valid", valid_cnt, vc);
        chk("late_ack_no_req", mem_req, 0);
        chk("rst_clears_overrun", overrun, 0);
        auto_ack = 1'b1;
        ack_lat = 2;
        n = req_log.size();
        expect_byte(8'h7F);
        rd(25'h0000301);
        wait_drain("post_rst_miss", 40);
        chk("post_rst_req_count", req_log.size(), n + 1);
        chk("post_rst_req_addr", req_log[n], 24'h000180);

        repeat (3) @(negedge clk_sys);
        chk("all_returns_seen", valid_cnt, push_cnt);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
